// File: rtl/toggle_period_monitor.sv
// toggle_period_monitor
//   Receive-side checker for the divided toggle output of a free-running
//   counter (level flips once every 2^WIDTH clocks). Flags every toggle edge
//   with a one-cycle pulse, measures the edge-to-edge interval, qualifies it
//   against the expected period and reports lock / sticky error status.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   en_i           : monitor enable; low forces IDLE
//   clear_i        : one-cycle request to drop lock/error and re-acquire
//   toggle_i       : toggle level from the source (same clock domain)
//   pulse_o        : one-cycle pulse per detected toggle edge
//   period_o       : last measured edge-to-edge interval, in clocks
//   period_valid_o : one-cycle strobe coincident with a period_o update
//   locked_o       : LOCK_CNT consecutive good periods seen, no fault since
//   error_o        : sticky fault flag, set only from LOCKED
//   err_count_o    : saturating fault counter (only with TOGGLE_ERR_CNT_EN)
//
// Build option: define TOGGLE_ERR_CNT_EN to add err_count_o and its counter.

module toggle_period_monitor #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CNT_W    = WIDTH + 2,
  parameter int unsigned TOL      = 1,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             toggle_i,
  output logic             pulse_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             error_o
`ifdef TOGGLE_ERR_CNT_EN
  ,
  output logic [7:0]       err_count_o
`endif
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

  // Acceptance window around the expected period 2^WIDTH
  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(2**WIDTH - TOL);
  localparam logic [CNT_W-1:0] PER_HI = CNT_W'(2**WIDTH + TOL);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEEK   = 3'd1;
  localparam logic [2:0] S_ACQ    = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               toggle_q, toggle_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               pv_q, pv_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;

  logic edge_c;
  logic good_c;
  logic timeout_c;

  // Edge / interval qualification
  assign edge_c    = toggle_i ^ toggle_q;
  assign good_c    = (cnt_q >= PER_LO) && (cnt_q <= PER_HI);
  assign timeout_c = !edge_c && (cnt_q > PER_HI);

  // Edge detector and saturating interval counter run regardless of state
  always_comb begin
    toggle_d = toggle_i;
    pulse_d  = edge_c;
    if (edge_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next-state / measurement logic; priority en_i=0 > clear_i > edge/timeout
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    period_d = period_q;
    pv_d     = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
      match_d = '0;
    end else if (clear_i) begin
      // An edge coinciding with clear is dropped; the counter still restarts
      state_d = S_SEEK;
      match_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SEEK;
        end
        S_SEEK: begin
          // First edge only opens the interval
          if (edge_c) begin
            state_d = S_ACQ;
            match_d = '0;
          end
        end
        S_ACQ: begin
          if (edge_c) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            if (good_c) begin
              if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                state_d = S_LOCKED;
                match_d = '0;
              end else begin
                match_d = match_q + MATCH_W'(1);
              end
            end else begin
              match_d = '0;
            end
          end else if (timeout_c) begin
            state_d = S_SEEK;
            match_d = '0;
          end
        end
        S_LOCKED: begin
          if (edge_c) begin
            period_d = cnt_q;
            pv_d     = 1'b1;
            if (!good_c) begin
              state_d = S_ERROR;
            end
          end else if (timeout_c) begin
            state_d = S_ERROR;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
          match_d = '0;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      match_q  <= '0;
      toggle_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      toggle_q <= toggle_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  assign pulse_o        = pulse_q;
  assign period_o       = period_q;
  assign period_valid_o = pv_q;
  assign locked_o       = locked_q;
  assign error_o        = error_q;

`ifdef TOGGLE_ERR_CNT_EN
  logic       fault_c;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts bad edges and timeouts while qualifying (ACQ) or locked
  always_comb begin
    fault_c   = ((state_q == S_ACQ) || (state_q == S_LOCKED)) &&
                ((edge_c && !good_c) || timeout_c);
    err_cnt_d = err_cnt_q;
    if (!en_i || clear_i) begin
      err_cnt_d = '0;
    end else if (fault_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule
